// File: rtl/openddr_pkg.sv
// openddr_pkg: shared APB register-file types and helpers for the OpenDDR controller.
// The optional byte-strobe feature of openddr_apb_regfile is selected by the
// OPENDDR_APB_PSTRB_EN macro.
package openddr_pkg;

  localparam int APB_MAX_WAIT = 15;
  localparam int APB_WAIT_W   = 4;

  typedef enum logic [1:0] {
    APB_OK,
    APB_MISALIGN,
    APB_RANGE,
    APB_STRB
  } apb_err_t;

  // Word index and byte offset of a bus address.
  typedef struct packed {
    logic [31:0] idx;
    logic [2:0]  off;
  } apb_addr_split_t;

  // Splits a byte address into its word index and the byte offset within the
  // word. off_w is log2 of the bytes per word (2 for 32-bit, 3 for 64-bit).
  function automatic apb_addr_split_t apb_split_addr(input logic [63:0] addr,
                                                     input int unsigned off_w);
    apb_addr_split_t s;
    s.idx = 32'(addr >> off_w);
    s.off = 3'(addr) & ((3'(1) << off_w) - 3'(1));
    return s;
  endfunction

endpackage

// File: rtl/openddr_w1c_status.sv
// openddr_w1c_status: sticky status bits with write-1-to-clear and an
// interrupt reduction. A set pulse and a clear on the same bit in the same
// cycle leave the bit set.
module openddr_w1c_status
  import openddr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_ST = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_ST*DATA_W-1:0] st_set,
  input  logic [NUM_ST*DATA_W-1:0] st_clr,
  output logic [NUM_ST*DATA_W-1:0] st_q,
  output logic                     irq
);

  logic [NUM_ST*DATA_W-1:0] st_d;

  // Next status: clear first, then OR in the set pulses so a set always wins.
  always_comb begin
    st_d = (st_q & ~st_clr) | st_set;
  end

  // Status storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign irq = |st_q;

endmodule

// File: rtl/openddr_apb_regfile.sv
// openddr_apb_regfile: APB4 slave with NUM_RW read/write configuration
// registers followed by NUM_ST sticky W1C status registers, programmable wait
// states and error response. Defining OPENDDR_APB_PSTRB_EN adds the pstrb
// port, byte-masked writes and an error on reads carrying nonzero strobes.
module openddr_apb_regfile
  import openddr_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int NUM_RW      = 32,
  parameter int NUM_ST      = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_RW*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [DATA_W-1:0]        pwdata,
`ifdef OPENDDR_APB_PSTRB_EN
  input  logic [DATA_W/8-1:0]      pstrb,
`endif
  output logic [DATA_W-1:0]        prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_RW*DATA_W-1:0] cfg_q,
  output logic [NUM_RW-1:0]        cfg_wr_stb,
  input  logic [NUM_ST*DATA_W-1:0] st_set,
  output logic                     irq
);

  localparam int STRB_W  = DATA_W / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int NUM_REG = NUM_RW + NUM_ST;
  localparam logic [APB_WAIT_W-1:0] WAIT_L = APB_WAIT_W'(WAIT_STATES);

  logic [APB_WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [NUM_RW*DATA_W-1:0] cfg_d;
  logic [NUM_RW-1:0]        cfg_wr_stb_q, cfg_wr_stb_d;
  logic [NUM_ST*DATA_W-1:0] st_q;
  logic [NUM_ST*DATA_W-1:0] st_clr;

  logic [STRB_W-1:0]  strb_w;
  logic [DATA_W-1:0]  wmask;
  apb_addr_split_t    split;
  apb_err_t           err;
  logic               access;
  logic               pready_w;
  logic               wr_ok;
  logic               rd_ok;
  logic [DATA_W-1:0]  prdata_w;

`ifdef OPENDDR_APB_PSTRB_EN
  assign strb_w = pstrb;
`else
  // Without strobes every write covers the whole word.
  assign strb_w = '1;
`endif

  assign split  = apb_split_addr(64'(paddr), OFF_W);
  assign access = psel & penable;
  // Gated by rst_n so a transfer held on the bus during reset never completes.
  assign pready_w = rst_n & access & (wait_cnt_q == WAIT_L);

  // Expand byte strobes into a bit mask.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      wmask[b*8 +: 8] = {8{strb_w[b]}};
    end
  end

  // Error cause for the current access, in priority order.
  always_comb begin
    err = APB_OK;
    if (split.off != '0) begin
      err = APB_MISALIGN;
    end else if (split.idx >= 32'(NUM_REG)) begin
      err = APB_RANGE;
`ifdef OPENDDR_APB_PSTRB_EN
    end else if (!pwrite && (pstrb != '0)) begin
      err = APB_STRB;
`endif
    end
  end

  assign wr_ok = pready_w & pwrite  & (err == APB_OK);
  assign rd_ok = pready_w & ~pwrite & (err == APB_OK);

  // Wait counter: counts access cycles until pready; cleared when the
  // transfer completes or when psel drops (abort).
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!psel || pready_w) begin
      wait_cnt_d = '0;
    end else if (access) begin
      wait_cnt_d = wait_cnt_q + APB_WAIT_W'(1);
    end
  end

  // Next config image and write strobes for an error-free write on pready.
  always_comb begin
    cfg_d        = cfg_q;
    cfg_wr_stb_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (wr_ok && (split.idx == 32'(i))) begin
        cfg_d[i*DATA_W +: DATA_W] = (cfg_q[i*DATA_W +: DATA_W] & ~wmask) |
                                    (pwdata & wmask);
        cfg_wr_stb_d[i]           = 1'b1;
      end
    end
  end

  // W1C clear mask for an error-free write into the status region.
  always_comb begin
    st_clr = '0;
    for (int j = 0; j < NUM_ST; j++) begin
      if (wr_ok && (split.idx == 32'(NUM_RW + j))) begin
        st_clr[j*DATA_W +: DATA_W] = pwdata & wmask;
      end
    end
  end

  // Read mux; status reads see the value before this cycle's set/clear.
  always_comb begin
    prdata_w = '0;
    if (rd_ok) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (split.idx == 32'(i)) begin
          prdata_w = cfg_q[i*DATA_W +: DATA_W];
        end
      end
      for (int j = 0; j < NUM_ST; j++) begin
        if (split.idx == 32'(NUM_RW + j)) begin
          prdata_w = st_q[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Wait counter, config registers and write strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      cfg_q        <= RST_VAL;
      cfg_wr_stb_q <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      cfg_q        <= cfg_d;
      cfg_wr_stb_q <= cfg_wr_stb_d;
    end
  end

  openddr_w1c_status #(
    .DATA_W (DATA_W),
    .NUM_ST (NUM_ST)
  ) u_status (
    .clk    (clk),
    .rst_n  (rst_n),
    .st_set (st_set),
    .st_clr (st_clr),
    .st_q   (st_q),
    .irq    (irq)
  );

  assign prdata     = prdata_w;
  assign pready     = pready_w;
  assign pslverr    = pready_w & (err != APB_OK);
  assign cfg_wr_stb = cfg_wr_stb_q;

endmodule

// File: tb/tb_openddr_apb_regfile.sv
// tb_openddr_apb_regfile: directed bench for openddr_apb_regfile. Two
// instances share the bus signals (separate psel): dut0 with zero wait states
// and dut3 with three. Byte-strobe vectors run when OPENDDR_APB_PSTRB_EN is set.
module tb_openddr_apb_regfile;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NRW = 32;
  localparam int NST = 8;
  // Register 1 = 0x00030000, register 3 = 0xFFFFFFFF, all others 0.
  localparam logic [NRW*DW-1:0] RV = (1024'h0003_0000 << 32) | (1024'hFFFF_FFFF << 96);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [DW/8-1:0] pstrb = '0;
  logic [NST*DW-1:0] st_set0 = '0, st_set3 = '0;

  logic [DW-1:0] prdata0, prdata3;
  logic pready0, pready3, pslverr0, pslverr3, irq0, irq3;
  logic [NRW*DW-1:0] cfg_q0, cfg_q3;
  logic [NRW-1:0] cfg_wr_stb0, cfg_wr_stb3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  openddr_apb_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_RW(NRW), .NUM_ST(NST),
                        .WAIT_STATES(0), .RST_VAL(RV)) dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef OPENDDR_APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .cfg_q(cfg_q0),
    .cfg_wr_stb(cfg_wr_stb0), .st_set(st_set0), .irq(irq0));

  openddr_apb_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_RW(NRW), .NUM_ST(NST),
                        .WAIT_STATES(3), .RST_VAL(RV)) dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef OPENDDR_APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3), .cfg_q(cfg_q3),
    .cfg_wr_stb(cfg_wr_stb3), .st_set(st_set3), .irq(irq3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input logic [NRW*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // One APB transfer on dut0 (d3=0) or dut3 (d3=1). Returns read data, error
  // flag and the number of access-phase cycles up to and including pready.
  task automatic xfer(input bit d3, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW/8-1:0] strb,
                      output logic [DW-1:0] rd, output logic err, output int ncyc);
    bit done;
    done = 1'b0;
    rd = '0;
    err = 1'b0;
    ncyc = 0;
    @(posedge clk); #1;
    if (d3) psel3 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ncyc++;
      if (d3 ? pready3 : pready0) begin
        rd = d3 ? prdata3 : prdata0;
        err = d3 ? pslverr3 : pslverr0;
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("xfer_timeout", 64'(ncyc), 64'(0));
    @(posedge clk); #1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    string         name;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [DW-1:0] rd;
    logic err;
    int ncyc;
    bit seen;

    vecs[0]  = '{"rd_reg1_rstval",   0, 10'h004, 32'h0,        32'h0003_0000, 1'b0};
    vecs[1]  = '{"rd_reg0_zero",     0, 10'h000, 32'h0,        32'h0,         1'b0};
    vecs[2]  = '{"wr_reg4",          1, 10'h010, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vecs[3]  = '{"rd_reg4",          0, 10'h010, 32'h0,        32'hA5A5_A5A5, 1'b0};
    vecs[4]  = '{"rd_misalign",      0, 10'h002, 32'h0,        32'h0,         1'b1};
    vecs[5]  = '{"rd_range_40",      0, 10'h0A0, 32'h0,        32'h0,         1'b1};
    vecs[6]  = '{"wr_range_40",      1, 10'h0A0, 32'h1234,     32'h0,         1'b1};
    vecs[7]  = '{"rd_last_status",   0, 10'h09C, 32'h0,        32'h0,         1'b0};
    vecs[8]  = '{"wr_misalign",      1, 10'h001, 32'hFFFF,     32'h0,         1'b1};
    vecs[9]  = '{"rd_reg0_unchgd",   0, 10'h000, 32'h0,        32'h0,         1'b0};
    vecs[10] = '{"rd_range_255",     0, 10'h3FC, 32'h0,        32'h0,         1'b1};
    vecs[11] = '{"rd_reg3_rstval",   0, 10'h00C, 32'h0,        32'hFFFF_FFFF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pready0", 64'(pready0), 64'(0));
    chk("rst_pslverr0", 64'(pslverr0), 64'(0));
    chk("rst_prdata0", 64'(prdata0), 64'(0));
    chk("rst_irq0", 64'(irq0), 64'(0));
    chk("rst_stb0", 64'(cfg_wr_stb0), 64'(0));
    chk("rst_cfg0", 64'(cfg_q0 == RV), 64'(1));
    chk("rst_cfg3", 64'(cfg_q3 == RV), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven single transfers on the zero-wait instance
    for (int v = 0; v < 12; v++) begin
      xfer(1'b0, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
           vecs[v].wr ? 4'hF : 4'h0, rd, err, ncyc);
      chk({vecs[v].name, "_rd"}, 64'(rd), 64'(vecs[v].exp_rd));
      chk({vecs[v].name, "_err"}, 64'(err), 64'(vecs[v].exp_err));
      chk({vecs[v].name, "_cyc"}, 64'(ncyc), 64'(1));
    end
    chk("cfg0_after_table", 64'(cfg_q0 == (RV | (1024'hA5A5_A5A5 << 128))), 64'(1));

    // Three wait states: write completes on the 4th access cycle
    xfer(1'b1, 1'b1, 10'h008, 32'hDEAD_BEEF, 4'hF, rd, err, ncyc);
    chk("ws3_wr_cyc", 64'(ncyc), 64'(4));
    chk("ws3_wr_err", 64'(err), 64'(0));
    chk("ws3_cfg2", 64'(slice(cfg_q3, 2)), 64'(32'hDEAD_BEEF));
    chk("ws3_stb", 64'(cfg_wr_stb3), 64'(32'h0000_0004));
    @(posedge clk); #1;
    chk("ws3_stb_drop", 64'(cfg_wr_stb3), 64'(0));

    // Status: sticky set, read, W1C, set-wins
    chk("irq0_idle", 64'(irq0), 64'(0));
    st_set0 = 256'h20;
    @(posedge clk); #1;
    st_set0 = '0;
    chk("irq0_set", 64'(irq0), 64'(1));
    xfer(1'b0, 1'b0, 10'h080, 32'h0, 4'h0, rd, err, ncyc);
    chk("st0_rd", 64'(rd), 64'(32'h20));
    xfer(1'b0, 1'b1, 10'h080, 32'h20, 4'hF, rd, err, ncyc);
    chk("st0_w1c_irq", 64'(irq0), 64'(0));
    xfer(1'b0, 1'b0, 10'h080, 32'h0, 4'h0, rd, err, ncyc);
    chk("st0_rd_clr", 64'(rd), 64'(32'h0));
    st_set0 = 256'h20;
    xfer(1'b0, 1'b1, 10'h080, 32'h20, 4'hF, rd, err, ncyc);
    st_set0 = '0;
    chk("st0_setwins_irq", 64'(irq0), 64'(1));
    xfer(1'b0, 1'b0, 10'h080, 32'h0, 4'h0, rd, err, ncyc);
    chk("st0_setwins_rd", 64'(rd), 64'(32'h20));

`ifdef OPENDDR_APB_PSTRB_EN
    // Byte-masked write over 0xFFFFFFFF, and a read carrying strobes
    xfer(1'b0, 1'b1, 10'h00C, 32'h1122_3344, 4'b0101, rd, err, ncyc);
    chk("strb_wr_err", 64'(err), 64'(0));
    xfer(1'b0, 1'b0, 10'h00C, 32'h0, 4'h0, rd, err, ncyc);
    chk("strb_rd", 64'(rd), 64'(32'hFF22_FF44));
    xfer(1'b0, 1'b0, 10'h00C, 32'h0, 4'h1, rd, err, ncyc);
    chk("strb_rd_err", 64'(err), 64'(1));
    chk("strb_rd_data", 64'(rd), 64'(0));
`endif

    // Abort: psel drops after two access cycles of a 3-wait write
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h014;
    pwdata = 32'h55AA_55AA; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_c1_rdy", 64'(pready3), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_c2_rdy", 64'(pready3), 64'(0));
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cfg_wr_stb3 != '0 || pready3) seen = 1'b1;
    end
    chk("abort_no_stb", 64'(seen), 64'(0));
    chk("abort_cfg5", 64'(slice(cfg_q3, 5)), 64'(0));
    xfer(1'b1, 1'b0, 10'h014, 32'h0, 4'h0, rd, err, ncyc);
    chk("abort_rd", 64'(rd), 64'(0));
    chk("abort_rd_cyc", 64'(ncyc), 64'(4));

    // Reset asserted in the middle of a 3-wait write
    @(posedge clk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h018;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_pready3", 64'(pready3), 64'(0));
    chk("midrst_pslverr3", 64'(pslverr3), 64'(0));
    chk("midrst_prdata3", 64'(prdata3), 64'(0));
    chk("midrst_stb3", 64'(cfg_wr_stb3), 64'(0));
    chk("midrst_cfg3", 64'(cfg_q3 == RV), 64'(1));
    chk("midrst_cfg0", 64'(cfg_q0 == RV), 64'(1));
    chk("midrst_irq0", 64'(irq0), 64'(0));
    @(posedge clk); #1;
    psel3 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_cfg6", 64'(slice(cfg_q3, 6)), 64'(0));
    xfer(1'b1, 1'b0, 10'h008, 32'h0, 4'h0, rd, err, ncyc);
    chk("postrst_rd2", 64'(rd), 64'(0));
    xfer(1'b0, 1'b0, 10'h004, 32'h0, 4'h0, rd, err, ncyc);
    chk("postrst_rd1", 64'(rd), 64'(32'h0003_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
